// File: rtl/spi_rx_master.sv
// Receive-only SPI master: frames 32 MISO bits (MSB first) with programmable
// chip-select setup/hold/idle timing and an SCLK half-period of CLK_DIV cycles.
module spi_rx_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_ena,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        spi_not_busy,
  output logic [31:0] spi_rx_data,
  output logic        rx_valid
);

  // state   | meaning
  // IDLE    | cs_n high, waiting for spi_ena
  // SETUP   | cs_n low, sclk low for CS_SETUP cycles
  // SHIFT   | 32 sclk periods, miso sampled on each rising sclk
  // HOLD    | cs_n low, sclk low for CS_HOLD cycles
  // RECOVER | cs_n high for CS_IDLE cycles before the next frame
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

  // Down-counter reload values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);

  logic [2:0]    state;
  logic [CW-1:0] phase_cnt;
  logic [5:0]    bit_cnt;
  logic [31:0]   shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase_cnt    <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      spi_not_busy <= 1'b1;
      spi_rx_data  <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (spi_ena) begin
            state        <= S_SETUP;
            cs_n         <= 1'b0;
            spi_not_busy <= 1'b0;
            phase_cnt    <= SETUP_LD;
            bit_cnt      <= '0;
            shift_reg    <= '0;
          end
        end
        S_SETUP: begin
          if (phase_cnt == '0) begin
            state     <= S_SHIFT;
            phase_cnt <= DIV_LD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (phase_cnt == '0) begin
            phase_cnt <= DIV_LD;
            if (!sclk) begin
              sclk      <= 1'b1;
              shift_reg <= {shift_reg[30:0], miso};
              bit_cnt   <= bit_cnt + 6'd1;
            end else begin
              sclk <= 1'b0;
              // The falling edge that closes the 32nd period also opens HOLD.
              if (bit_cnt == 6'd32) begin
                state     <= S_HOLD;
                phase_cnt <= HOLD_LD;
              end
            end
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (phase_cnt == '0) begin
            state       <= S_RECOVER;
            cs_n        <= 1'b1;
            spi_rx_data <= shift_reg;
            rx_valid    <= 1'b1;
            phase_cnt   <= IDLE_LD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (phase_cnt == '0) begin
            state        <= S_IDLE;
            spi_not_busy <= 1'b1;
            bit_cnt      <= '0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          sclk         <= 1'b0;
          cs_n         <= 1'b1;
          spi_not_busy <= 1'b1;
          phase_cnt    <= '0;
          bit_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_master.sv
// Bench for spi_rx_master: a behavioural MISO slave per DUT plus frame monitors,
// checked against words queued to the slave and timing derived from the parameters.
module tb_spi_rx_master;

  localparam int D0 = 2, S0 = 2, H0 = 2, I0 = 2;
  localparam int LOW0 = S0 + 64 * D0 + H0;
  localparam int LOW1 = 1 + 64 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default-parameter instance
  logic rst = 1'b1, spi_ena = 1'b0, miso = 1'b0;
  logic sclk, cs_n, nb, rxv;
  logic [31:0] rxd;

  spi_rx_master u0 (
    .clk(clk), .rst(rst), .spi_ena(spi_ena), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .spi_not_busy(nb),
    .spi_rx_data(rxd), .rx_valid(rxv)
  );

  // minimum-timing instance
  logic rst1 = 1'b1, ena1 = 1'b0, miso1 = 1'b0;
  logic sclk1, cs_n1, nb1, rxv1;
  logic [31:0] rxd1;

  spi_rx_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u1 (
    .clk(clk), .rst(rst1), .spi_ena(ena1), .miso(miso1),
    .sclk(sclk1), .cs_n(cs_n1), .spi_not_busy(nb1),
    .spi_rx_data(rxd1), .rx_valid(rxv1)
  );

  // Slave models: present bit 31 when cs_n falls, next bit on each sclk fall.
  logic [31:0] slv_q[$], slv1_q[$];
  logic [31:0] cur = '0, cur1 = '0;
  int idx = -1, idx1 = -1;
  logic cs_p = 1'b1, sc_p = 1'b0, cs1_p = 1'b1, sc1_p = 1'b0;

  always @(cs_n, sclk) begin
    if (cs_n === 1'b0 && cs_p === 1'b1) begin
      cur = (slv_q.size() > 0) ? slv_q.pop_front() : 32'h0;
      miso = cur[31];
      idx = 30;
    end else if (cs_n === 1'b0 && sclk === 1'b0 && sc_p === 1'b1 && idx >= 0) begin
      miso = cur[idx];
      idx--;
    end
    cs_p = cs_n;
    sc_p = sclk;
  end

  always @(cs_n1, sclk1) begin
    if (cs_n1 === 1'b0 && cs1_p === 1'b1) begin
      cur1 = (slv1_q.size() > 0) ? slv1_q.pop_front() : 32'h0;
      miso1 = cur1[31];
      idx1 = 30;
    end else if (cs_n1 === 1'b0 && sclk1 === 1'b0 && sc1_p === 1'b1 && idx1 >= 0) begin
      miso1 = cur1[idx1];
      idx1--;
    end
    cs1_p = cs_n1;
    sc1_p = sclk1;
  end

  // Frame monitors, sampled on the falling clk edge.
  logic [31:0] rx_seen[$], rx1_seen[$];
  int gap_q[$], gap1_q[$];
  int low_run = 0, high_run = 0, rises = 0, last_low = 0, last_rises = 0, starts = 0;
  int sclk_viol = 0, wide = 0;
  logic cs_m = 1'b1, sclk_m = 1'b0, rxv_m = 1'b0;
  int low1_run = 0, high1_run = 0, rises1 = 0, last_low1 = 0, last_rises1 = 0, starts1 = 0;
  int sclk1_viol = 0, wide1 = 0;
  logic cs1_m = 1'b1, sclk1_m = 1'b0, rxv1_m = 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      if (cs_m === 1'b1) begin
        gap_q.push_back(high_run);
        starts++;
        low_run = 0;
        rises = 0;
      end
      low_run++;
      if (sclk === 1'b1 && sclk_m === 1'b0) rises++;
    end else begin
      if (cs_m === 1'b0) begin
        last_low = low_run;
        last_rises = rises;
        high_run = 0;
      end
      high_run++;
      if (sclk === 1'b1) sclk_viol++;
    end
    if (rxv === 1'b1) begin
      rx_seen.push_back(rxd);
      if (rxv_m === 1'b1) wide++;
    end
    cs_m = cs_n; sclk_m = sclk; rxv_m = rxv;

    if (cs_n1 === 1'b0) begin
      if (cs1_m === 1'b1) begin
        gap1_q.push_back(high1_run);
        starts1++;
        low1_run = 0;
        rises1 = 0;
      end
      low1_run++;
      if (sclk1 === 1'b1 && sclk1_m === 1'b0) rises1++;
    end else begin
      if (cs1_m === 1'b0) begin
        last_low1 = low1_run;
        last_rises1 = rises1;
        high1_run = 0;
      end
      high1_run++;
      if (sclk1 === 1'b1) sclk1_viol++;
    end
    if (rxv1 === 1'b1) begin
      rx1_seen.push_back(rxd1);
      if (rxv1_m === 1'b1) wide1++;
    end
    cs1_m = cs_n1; sclk1_m = sclk1; rxv1_m = rxv1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (rx_seen.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_rx1(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (rx1_seen.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (nb !== 1'b1) begin failures++; $display("FAIL reset_not_busy got=%b exp=1", nb); end
    checks++; if (rxv !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rxv); end
    checks++; if (rxd !== 32'h0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0", rxd); end
  endtask

  task automatic test_single();
    logic [31:0] words[4];
    bit ok;
    int base;
    words[0] = 32'hA5A50F01;
    for (int k = 1; k < 4; k++) words[k] = $urandom;
    for (int k = 0; k < 4; k++) begin
      slv_q.push_back(words[k]);
      base = rx_seen.size();
      spi_ena = 1'b1;
      step();
      spi_ena = 1'b0;
      wait_rx(base + 1, 400, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL single_timeout frame=%0d got=no_rx exp=rx_valid", k);
      end else begin
        checks++; if (rx_seen[base] !== words[k]) begin failures++; $display("FAIL single_data frame=%0d got=%h exp=%h", k, rx_seen[base], words[k]); end
        checks++; if (last_rises !== 32) begin failures++; $display("FAIL single_sclk_rises frame=%0d got=%0d exp=32", k, last_rises); end
        checks++; if (last_low !== LOW0) begin failures++; $display("FAIL single_cs_low frame=%0d got=%0d exp=%0d", k, last_low, LOW0); end
      end
      repeat (I0 + 4) step();
      checks++; if (rx_seen.size() !== base + 1) begin failures++; $display("FAIL single_pulses frame=%0d got=%0d exp=%0d", k, rx_seen.size(), base + 1); end
      checks++; if (rxd !== words[k]) begin failures++; $display("FAIL single_hold_data frame=%0d got=%h exp=%h", k, rxd, words[k]); end
    end
    checks++; if (wide !== 0) begin failures++; $display("FAIL rx_valid_width got=%0d exp=0", wide); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3];
    bit ok;
    int base, s0, guard;
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'h00000000;
    words[2] = $urandom | 32'h1;
    for (int k = 0; k < 3; k++) slv_q.push_back(words[k]);
    base = rx_seen.size();
    s0 = starts;
    spi_ena = 1'b1;
    guard = 0;
    while (starts < s0 + 3 && guard < 800) begin
      step();
      guard++;
    end
    spi_ena = 1'b0;
    wait_rx(base + 3, 800, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_timeout got=%0d exp=%0d frames", rx_seen.size() - base, 3);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (rx_seen[base + k] !== words[k]) begin failures++; $display("FAIL b2b_data frame=%0d got=%h exp=%h", k, rx_seen[base + k], words[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++; if (gap_q[s0 + k] !== I0 + 1) begin failures++; $display("FAIL b2b_cs_gap frame=%0d got=%0d exp=%0d", k, gap_q[s0 + k], I0 + 1); end
      end
    end
    repeat (300) step();
    checks++; if (starts !== s0 + 3) begin failures++; $display("FAIL b2b_frame_count got=%0d exp=%0d", starts - s0, 3); end
  endtask

  task automatic test_ena_ignored();
    logic [31:0] w;
    bit ok;
    int base, s0, guard;
    w = $urandom | 32'h1;
    slv_q.push_back(w);
    base = rx_seen.size();
    s0 = starts;
    spi_ena = 1'b1;
    step();
    spi_ena = 1'b0;
    guard = 0;
    while (rises < 5 && guard < 400) begin
      step();
      guard++;
    end
    spi_ena = 1'b1;
    step();
    spi_ena = 1'b0;
    guard = 0;
    while (rxv !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    spi_ena = 1'b1;
    step();
    spi_ena = 1'b0;
    wait_rx(base + 1, 400, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL ignore_timeout got=no_rx exp=rx_valid");
    end else begin
      checks++; if (rx_seen[base] !== w) begin failures++; $display("FAIL ignore_data got=%h exp=%h", rx_seen[base], w); end
      checks++; if (last_low !== LOW0) begin failures++; $display("FAIL ignore_cs_low got=%0d exp=%0d", last_low, LOW0); end
      checks++; if (last_rises !== 32) begin failures++; $display("FAIL ignore_sclk_rises got=%0d exp=32", last_rises); end
    end
    repeat (300) step();
    checks++; if (starts !== s0 + 1) begin failures++; $display("FAIL ignore_extra_frame got=%0d exp=1", starts - s0); end
    checks++; if (rx_seen.size() !== base + 1) begin failures++; $display("FAIL ignore_extra_rx got=%0d exp=1", rx_seen.size() - base); end
  endtask

  task automatic test_reset_mid();
    int base, guard;
    slv_q.push_back($urandom);
    base = rx_seen.size();
    spi_ena = 1'b1;
    step();
    guard = 0;
    while (rises < 10 && guard < 400) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    spi_ena = 1'b0;
    checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL midrst_cs_n got=%b exp=1", cs_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
    checks++; if (nb !== 1'b1) begin failures++; $display("FAIL midrst_not_busy got=%b exp=1", nb); end
    checks++; if (rxd !== 32'h0) begin failures++; $display("FAIL midrst_rx_data got=%h exp=0", rxd); end
    rst = 1'b0;
    repeat (300) step();
    checks++; if (rx_seen.size() !== base) begin failures++; $display("FAIL midrst_rx_pulse got=%0d exp=0", rx_seen.size() - base); end
    checks++; if (rxd !== 32'h0) begin failures++; $display("FAIL midrst_rx_hold got=%h exp=0", rxd); end
  endtask

  task automatic test_handshake();
    logic [31:0] w;
    int low_cnt, guard;
    w = $urandom;
    slv_q.push_back(w);
    guard = 0;
    while (nb !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    spi_ena = 1'b1;
    step();
    checks++; if (nb !== 1'b0) begin failures++; $display("FAIL hs_busy_rise got=%b exp=0", nb); end
    spi_ena = 1'b0;
    low_cnt = 1;
    guard = 0;
    while (guard < 400) begin
      step();
      guard++;
      if (nb === 1'b0) low_cnt++;
      else break;
    end
    checks++; if (low_cnt !== LOW0 + I0) begin failures++; $display("FAIL hs_busy_cycles got=%0d exp=%0d", low_cnt, LOW0 + I0); end
    checks++; if (rxd !== w) begin failures++; $display("FAIL hs_data got=%h exp=%h", rxd, w); end
  endtask

  task automatic test_fast();
    logic [31:0] words[2];
    bit ok;
    int s0, guard;
    words[0] = 32'h80000001;
    words[1] = $urandom;
    rst1 = 1'b1;
    repeat (2) step();
    rst1 = 1'b0;
    step();
    checks++; if (cs_n1 !== 1'b1 || sclk1 !== 1'b0 || nb1 !== 1'b1 || rxd1 !== 32'h0)
      begin failures++; $display("FAIL fast_reset got=cs%b/sclk%b/nb%b/%h exp=cs1/sclk0/nb1/0", cs_n1, sclk1, nb1, rxd1); end
    slv1_q.push_back(words[0]);
    slv1_q.push_back(words[1]);
    s0 = starts1;
    ena1 = 1'b1;
    guard = 0;
    while (starts1 < s0 + 2 && guard < 400) begin
      step();
      guard++;
    end
    ena1 = 1'b0;
    wait_rx1(2, 400, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL fast_timeout got=%0d exp=2 frames", rx1_seen.size());
    end else begin
      checks++; if (rx1_seen[0] !== words[0]) begin failures++; $display("FAIL fast_data0 got=%h exp=%h", rx1_seen[0], words[0]); end
      checks++; if (rx1_seen[1] !== words[1]) begin failures++; $display("FAIL fast_data1 got=%h exp=%h", rx1_seen[1], words[1]); end
      checks++; if (last_low1 !== LOW1) begin failures++; $display("FAIL fast_cs_low got=%0d exp=%0d", last_low1, LOW1); end
      checks++; if (last_rises1 !== 32) begin failures++; $display("FAIL fast_sclk_rises got=%0d exp=32", last_rises1); end
      checks++; if (gap1_q[s0 + 1] !== 2) begin failures++; $display("FAIL fast_cs_gap got=%0d exp=2", gap1_q[s0 + 1]); end
    end
    checks++; if (wide1 !== 0) begin failures++; $display("FAIL fast_rx_valid_width got=%0d exp=0", wide1); end
  endtask

  task automatic test_sclk_quiet();
    checks++; if (sclk_viol !== 0) begin failures++; $display("FAIL sclk_while_cs_high got=%0d exp=0", sclk_viol); end
    checks++; if (sclk1_viol !== 0) begin failures++; $display("FAIL fast_sclk_while_cs_high got=%0d exp=0", sclk1_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ena_ignored();
    test_reset_mid();
    test_handshake();
    test_fast();
    test_sclk_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_master.md
SPI_RX_MASTER -- requirements
Module: spi_rx_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal range >=1.
REQ-002 SHALL have parameter CS_SETUP, default 2: cycles from cs_n falling to the first SCLK low half; legal range >=1.
REQ-003 SHALL have parameter CS_HOLD, default 2: cycles from the last SCLK falling edge to cs_n rising; legal range >=1.
REQ-004 SHALL have parameter CS_IDLE, default 2: minimum cs_n-high cycles between frames; legal range >=1.
REQ-005 SHALL have port clk  input  1  rising-edge system clock.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port spi_ena  input  1  frame request, sampled only in IDLE.
REQ-008 SHALL have port miso  input  1  serial data from the thermocouple converter, MSB first.
REQ-009 SHALL have port sclk  output  1  SPI clock, idles low.
REQ-010 SHALL have port cs_n  output  1  chip select, active low.
REQ-011 SHALL have port spi_not_busy  output  1  high only in IDLE.
REQ-012 SHALL have port spi_rx_data  output  32  last completed frame, bit 31 = first bit received.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse when spi_rx_data updates.

Function
REQ-014 SHALL register all outputs; no combinational input-to-output path.
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, HOLD, RECOVER.
REQ-016 IDLE: cs_n=1, sclk=0, spi_not_busy=1; spi_ena=1 at an edge -> SETUP, with cs_n=0 and spi_not_busy=0 from the next cycle.
REQ-017 SETUP: lasts CS_SETUP cycles; sclk=0, cs_n=0; then -> SHIFT.
REQ-018 SHIFT: 32 bit periods of 2*CLK_DIV cycles; each period is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-019 SHALL sample miso into a 32-bit left-shifting register at the clk edge where sclk is driven low->high; exactly 32 samples per frame.
REQ-020 After the 32nd high half, sclk SHALL return low and the state SHALL go to HOLD.
REQ-021 HOLD: lasts CS_HOLD cycles; sclk=0, cs_n=0.
REQ-022 At HOLD exit, on one edge: cs_n<=1, spi_rx_data<=shift register, rx_valid<=1, state RECOVER.
REQ-023 RECOVER: lasts CS_IDLE cycles; cs_n=1, spi_not_busy=0, rx_valid low after its first cycle; then -> IDLE.
REQ-024 cs_n low time per frame SHALL equal CS_SETUP + 64*CLK_DIV + CS_HOLD cycles exactly (132 at defaults).
REQ-025 spi_rx_data SHALL hold its value between rx_valid pulses; partial frames never appear on it.
REQ-026 spi_ena SHALL be ignored outside IDLE; spi_ena held high yields back-to-back frames separated by exactly CS_IDLE + 1 cs_n-high cycles.
REQ-027 sclk SHALL never toggle while cs_n=1.
REQ-028 Bit and phase counters SHALL be sized to hold 32 and max(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) without wrap.

Reset
REQ-029 On rst=1 at any edge, the next cycle SHALL be: state IDLE, cs_n=1, sclk=0, spi_not_busy=1, rx_valid=0, spi_rx_data=0, shift register and counters 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no rx_valid pulse; rst dominates spi_ena.

Verification
REQ-031 Defaults, miso model returns 0xA5A50F01 -> exactly 32 sclk rising edges, cs_n low 132 cycles, rx_valid one cycle, spi_rx_data=0xA5A50F01.
REQ-032 spi_ena held high, frames 0xFFFFFFFF then 0x00000000 -> spi_rx_data takes each value in order; cs_n high exactly 3 cycles between frames.
REQ-033 rst asserted after the 10th sclk rising edge -> next cycle cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0, no rx_valid.
REQ-034 spi_ena pulsed during SHIFT and RECOVER -> no extra frame and no change in timing.
REQ-035 CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1, data 0x80000001 -> cs_n low 66 cycles, spi_rx_data=0x80000001.
REQ-036 Handshake with the thermocouple reader (spi_ena held while spi_not_busy=1) -> spi_not_busy falls one cycle after spi_ena rises and stays low until RECOVER ends.
